// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter (start, LSB-first data,
// optional even parity, stop), valid/ready payload input.
// Ports:
//   clk, areset      clock, synchronous active-high reset
//   in_data/valid    payload offer, taken when in_ready
//   in_ready         high in IDLE only
//   out              registered serial line, idles at 1
//   busy, done       frame active, last stop-bit cycle
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int CW = 8;
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_W - 1);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_out;

  state_t            w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [IW-1:0]     w_idx_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_par_nxt;
  logic              w_out_nxt;
  logic              w_bit_end;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_bit_end   = (r_cnt == CNT_LAST);

    // Bit-cycle counter reloads on every bit boundary.
    if (r_state != S_IDLE) begin
      if (w_bit_end) w_cnt_nxt = '0;
      else           w_cnt_nxt = r_cnt + 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = in_data;
          w_par_nxt   = ^in_data;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ?
                          S_PARITY : S_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level follows the state being entered so
    // that out is a flop, not a decode.
    unique case (w_state_nxt)
      S_START:  w_out_nxt = 1'b0;
      S_DATA:   w_out_nxt = w_shift_nxt[0];
      S_PARITY: w_out_nxt = w_par_nxt;
      default:  w_out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_out   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_STOP) &&
                    (r_cnt == CNT_LAST);
  assign out      = r_out;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for serial_frame_tx,
// default build plus PARITY_EN=0, CLKS_PER_BIT=1 build.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       a_rst;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready, a_out, a_busy, a_done;

  logic       b_rst;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready, b_out, b_busy, b_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_frame_tx dut_a (
    .clk      (clk),
    .areset   (a_rst),
    .in_data  (a_data),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .out      (a_out),
    .busy     (a_busy),
    .done     (a_done)
  );

  serial_frame_tx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (1),
    .PARITY_EN    (0)
  ) dut_b (
    .clk      (clk),
    .areset   (b_rst),
    .in_data  (b_data),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .out      (b_out),
    .busy     (b_busy),
    .done     (b_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot k of a frame.
  function automatic logic exp_bit(
    input logic [7:0] d, input bit par_en,
    input int k);
    if (k == 0)              return 1'b0;
    if (k <= 8)              return d[k-1];
    if (k == 9 && par_en)    return ^d;
    return 1'b1;
  endfunction

  task automatic check_idle_a(input string tag);
    check({tag, " out"},   32'(a_out),   32'd1);
    check({tag, " ready"}, 32'(a_ready), 32'd1);
    check({tag, " busy"},  32'(a_busy),  32'd0);
    check({tag, " done"},  32'(a_done),  32'd0);
  endtask

  // Offer d, handshake, then watch all 44 cycles.
  // nd is driven on in_data right after the handshake.
  task automatic run_frame(input logic [7:0] d,
                           input logic [7:0] nd,
                           input bit hold,
                           input bit pulse);
    a_data  = d;
    a_valid = 1'b1;
    tick();
    a_data  = nd;
    a_valid = hold;
    for (int c = 1; c <= 44; c++) begin
      if (pulse && c == 10) a_valid = 1'b1;
      if (pulse && c == 11) a_valid = 1'b0;
      check($sformatf("A%0h out c%0d", d, c),
            32'(a_out),
            32'(exp_bit(d, 1'b1, (c - 1) / 4)));
      check($sformatf("A%0h done c%0d", d, c),
            32'(a_done), 32'(c == 44));
      check($sformatf("A%0h busy c%0d", d, c),
            32'(a_busy), 32'd1);
      check($sformatf("A%0h ready c%0d", d, c),
            32'(a_ready), 32'd0);
      if (c < 44) tick();
    end
    tick();
    check_idle_a($sformatf("A%0h gap", d));
  endtask

  initial begin
    a_rst   = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'hA5;
    b_rst   = 1'b1;
    b_valid = 1'b0;
    b_data  = 8'h00;

    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle_a($sformatf("rst%0d", i));
    end
    a_rst = 1'b0;
    b_rst = 1'b0;

    // First handshake taken right after reset release.
    run_frame(8'hA5, 8'h5A, 1'b0, 1'b0);

    // Back-to-back with valid held: one idle cycle.
    run_frame(8'h01, 8'hFF, 1'b1, 1'b0);
    run_frame(8'hFF, 8'h00, 1'b0, 1'b0);

    // Data churn and a stray valid pulse mid-frame.
    run_frame(8'h96, 8'h3F, 1'b0, 1'b1);
    tick();
    check("stray dropped busy", 32'(a_busy), 32'd0);
    check("stray dropped out",  32'(a_out),  32'd1);

    // Abort 0x3C at cycle 10.
    a_data  = 8'h3C;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("abort pre out", 32'(a_out),
          32'(exp_bit(8'h3C, 1'b1, 9 / 4)));
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      check_idle_a($sformatf("abort c%0d", c));
      tick();
    end
    run_frame(8'h3C, 8'h00, 1'b0, 1'b0);

    // No parity, one clock per bit.
    b_data  = 8'h80;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("B out c%0d", c), 32'(b_out),
            32'(exp_bit(8'h80, 1'b0, c - 1)));
      check($sformatf("B done c%0d", c),
            32'(b_done), 32'(c == 10));
      check($sformatf("B busy c%0d", c),
            32'(b_busy), 32'd1);
      tick();
    end
    check("B idle ready", 32'(b_ready), 32'd1);
    check("B idle out",   32'(b_out),   32'd1);
    check("B idle busy",  32'(b_busy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
